// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: definitions shared by the sequential ALU, its iterative
// datapath and its testbench.
//   - OP_* : 4-bit opcode map (identical to the older combinational ALU)
//   - ST_* : FSM state encoding, also driven out on seq_alu.fsm_state
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative unsigned multiply (shift-add) and restoring divide.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : load operands and perform the first iteration
//   is_div              : 1 = divide, 0 = multiply (sampled with start)
//   operand1, operand2  : multiplicand/multiplier or dividend/divisor
//   done                : all WIDTH iterations have completed
//   product             : 2*WIDTH-bit product (multiply)
//   quotient, remainder : divide results
// The working registers hi/lo are shared by both operations:
//   multiply: {hi, lo} is the partial product, lo starts as the multiplier
//   divide  : hi is the partial remainder, lo shifts dividend out / quotient in
module seq_alu_iter import seq_alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;

    logic             cur_div;
    logic [WIDTH-1:0] cur_hi, cur_lo, cur_m;
    logic [WIDTH:0]   addend, sum;
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    // The first iteration runs on the edge that loads the operands, so the
    // step logic reads the raw operands when start is high. WIDTH iterations
    // therefore finish WIDTH-1 edges after start.
    always_comb begin
        cur_div = start ? is_div : div_q;
        cur_hi  = start ? '0 : hi_q;
        cur_lo  = start ? (is_div ? operand1 : operand2) : lo_q;
        cur_m   = start ? (is_div ? operand2 : operand1) : m_q;

        // shift-add: add multiplicand when the current multiplier bit is set
        addend  = cur_lo[0] ? {1'b0, cur_m} : '0;
        sum     = {1'b0, cur_hi} + addend;

        // restoring: a clear top bit of the trial difference means it fits
        shifted = {cur_hi, cur_lo[WIDTH-1]};
        trial   = shifted - {1'b0, cur_m};
        fits    = ~trial[WIDTH];

        if (cur_div) begin
            nxt_hi = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], fits};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], cur_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= nxt_hi;
            lo_q  <= nxt_lo;
            m_q   <= cur_m;
            div_q <= is_div;
            cnt_q <= CNT_LOAD;
        end else if (cnt_q != '0) begin
            hi_q  <= nxt_hi;
            lo_q  <= nxt_lo;
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    assign done      = (cnt_q == '0);
    assign product   = {hi_q, lo_q};
    assign quotient  = lo_q;
    assign remainder = hi_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with iterative multiply/divide and status flags.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   in_valid, in_ready     : request handshake
//   opcode, operand1/2     : request payload (see OP_* in seq_alu_pkg)
//   out_valid, out_ready   : response handshake
//   result, remainder      : response data (remainder only for divide)
//   flag_zero/carry/overflow/dbz : status flags for the response
//   fsm_state              : current FSM state (ST_* encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; the
// response payload is held stable for as long as out_valid waits for
// out_ready, and ready never depends combinationally on valid.
module seq_alu import seq_alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             flag_dbz,
    output logic [1:0]       fsm_state
);

    logic [1:0]       state;
    logic             exec_div_q;

    logic             goes_iter, start;
    logic             it_done;
    logic [2*WIDTH-1:0] it_product;
    logic [WIDTH-1:0] it_quotient, it_remainder;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] s_res, s_rem;
    logic             s_carry, s_ovf, s_dbz;

    logic [WIDTH-1:0] x_res;
    logic             x_carry;

    // Divide by zero never enters EXEC; it is answered by the single-cycle path.
    assign goes_iter = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand2 != '0));
    assign start     = (state == ST_IDLE) && in_valid && goes_iter;

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_div    (opcode == OP_DIV),
        .operand1  (operand1),
        .operand2  (operand2),
        .done      (it_done),
        .product   (it_product),
        .quotient  (it_quotient),
        .remainder (it_remainder)
    );

    // Single-cycle operations, evaluated on the accepted request.
    always_comb begin
        sum_ext = {1'b0, operand1} + {1'b0, operand2};
        diff    = operand1 - operand2;
        s_res   = '0;
        s_rem   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_dbz   = 1'b0;
        case (opcode)
            OP_ADD: begin
                s_res   = sum_ext[WIDTH-1:0];
                s_carry = sum_ext[WIDTH];
                s_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                          (s_res[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                s_res   = diff;
                s_carry = (operand1 < operand2);
                s_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                          (s_res[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_DIV: begin
                // only reached with a zero divisor
                s_res = '1;
                s_rem = operand1;
                s_dbz = 1'b1;
            end
            OP_SHL: begin
                s_res   = {operand1[WIDTH-2:0], 1'b0};
                s_carry = operand1[WIDTH-1];
            end
            OP_SHR: begin
                s_res   = {1'b0, operand1[WIDTH-1:1]};
                s_carry = operand1[0];
            end
            OP_ROL: begin
                s_res   = {operand1[WIDTH-2:0], operand1[WIDTH-1]};
                s_carry = operand1[WIDTH-1];
            end
            OP_ROR: begin
                s_res   = {operand1[0], operand1[WIDTH-1:1]};
                s_carry = operand1[0];
            end
            OP_AND:  s_res = operand1 & operand2;
            OP_OR:   s_res = operand1 | operand2;
            OP_XOR:  s_res = operand1 ^ operand2;
            OP_NOR:  s_res = ~(operand1 | operand2);
            OP_NAND: s_res = ~(operand1 & operand2);
            OP_XNOR: s_res = ~(operand1 ^ operand2);
            OP_GT:   s_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
            OP_EQ:   s_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
            default: s_res = '0;
        endcase
    end

    // Iterative results selected by the operation latched at accept.
    assign x_res   = exec_div_q ? it_quotient : it_product[WIDTH-1:0];
    assign x_carry = exec_div_q ? 1'b0 : (it_product[2*WIDTH-1:WIDTH] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            exec_div_q    <= 1'b0;
            result        <= '0;
            remainder     <= '0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            flag_overflow <= 1'b0;
            flag_dbz      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        exec_div_q <= (opcode == OP_DIV);
                        if (goes_iter) begin
                            state <= ST_EXEC;
                        end else begin
                            state         <= ST_DONE;
                            result        <= s_res;
                            remainder     <= s_rem;
                            flag_zero     <= (s_res == '0);
                            flag_carry    <= s_carry;
                            flag_overflow <= s_ovf;
                            flag_dbz      <= s_dbz;
                        end
                    end
                end
                ST_EXEC: begin
                    if (it_done) begin
                        state         <= ST_DONE;
                        result        <= x_res;
                        remainder     <= exec_div_q ? it_remainder : '0;
                        flag_zero     <= (x_res == '0);
                        flag_carry    <= x_carry;
                        flag_overflow <= 1'b0;
                        flag_dbz      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] operand1, operand2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, remainder;
  logic         flag_zero, flag_carry, flag_overflow, flag_dbz;
  logic [1:0]   fsm_state;

  seq_alu #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .operand1      (operand1),
    .operand2      (operand2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .remainder     (remainder),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry),
    .flag_overflow (flag_overflow),
    .flag_dbz      (flag_dbz),
    .fsm_state     (fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: {result, remainder, zero, carry, overflow, dbz}
  logic [2*W+3:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic [3:0]   flags;  // {zero, carry, overflow, dbz}
    int           lat;
  } vec_t;

  localparam int NFIX = 25;
  localparam int NRND = 20;
  vec_t vecs[NFIX + NRND];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // reference model for random vectors
  function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic           c, o, d;
    v.op = op; v.a = a; v.b = b;
    v.res = '0; v.rem = '0; c = 1'b0; o = 1'b0; d = 1'b0;
    v.lat = 1;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        v.res = s[W-1:0]; c = s[W];
        o = (a[W-1] == b[W-1]) && (v.res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        v.res = a - b; c = (a < b);
        o = (a[W-1] != b[W-1]) && (v.res[W-1] != a[W-1]);
      end
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        v.res = p[W-1:0]; c = (p[2*W-1:W] != '0); v.lat = W + 1;
      end
      OP_DIV: begin
        if (b == '0) begin
          v.res = '1; v.rem = a; d = 1'b1;
        end else begin
          v.res = a / b; v.rem = a % b; v.lat = W + 1;
        end
      end
      OP_SHL:  begin v.res = a << 1; c = a[W-1]; end
      OP_SHR:  begin v.res = a >> 1; c = a[0]; end
      OP_ROL:  begin v.res = (a << 1) | (a >> (W - 1)); c = a[W-1]; end
      OP_ROR:  begin v.res = (a >> 1) | (a << (W - 1)); c = a[0]; end
      OP_AND:  v.res = a & b;
      OP_OR:   v.res = a | b;
      OP_XOR:  v.res = a ^ b;
      OP_NOR:  v.res = ~(a | b);
      OP_NAND: v.res = ~(a & b);
      OP_XNOR: v.res = ~(a ^ b);
      OP_GT:   v.res = (a > b) ? 1 : 0;
      default: v.res = (a == b) ? 1 : 0;
    endcase
    v.flags = {(v.res == '0), c, o, d};
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic [W-1:0] rem,
                              input logic [3:0] flags, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.rem = rem; v.flags = flags; v.lat = lat;
    return v;
  endfunction

  // driver: issue one request, wait for the response, optionally stall it
  task automatic run_op(input vec_t v, input int hold, input bit early);
    int lat;
    int ir_bad;
    logic [2*W+3:0] e;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    opcode    = v.op;
    operand1  = v.a;
    operand2  = v.b;
    out_ready = early;
    exp_q.push_back({v.res, v.rem, v.flags});
    @(posedge clk);
    #1;
    // scramble inputs: the accepted request must already be registered
    in_valid = 1'b0;
    opcode   = 4'($urandom_range(15));
    operand1 = W'($urandom);
    operand2 = W'($urandom);
    lat = 1;
    ir_bad = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) ir_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      check("timeout", out_valid, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      out_ready = 1'b0;
      return;
    end
    check("latency", lat, v.lat);
    check("in_ready_busy", ir_bad, 0);
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("response", {result, remainder, flag_zero, flag_carry, flag_overflow, flag_dbz}, e);
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        check("held", {out_valid, in_ready, result, remainder,
                       flag_zero, flag_carry, flag_overflow, flag_dbz}, {2'b10, e});
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after", {fsm_state, out_valid, in_ready}, {ST_IDLE, 2'b01});
  endtask

  initial begin
    int spur;

    // fixed vectors: {op, a, b, result, remainder, {z,c,v,dbz}, latency}
    vecs[0]  = mk(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1);
    vecs[1]  = mk(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0010, 1);
    vecs[2]  = mk(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 16'h0000, 4'b1100, 17);
    vecs[3]  = mk(OP_DIV,  16'd1000, 16'd7,    16'd142,  16'd6,    4'b0000, 17);
    vecs[4]  = mk(OP_DIV,  16'd1000, 16'd0,    16'hFFFF, 16'd1000, 4'b0001, 1);
    vecs[5]  = mk(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0010, 1);
    vecs[6]  = mk(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0100, 1);
    vecs[7]  = mk(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 4'b0100, 17);
    vecs[8]  = mk(OP_MUL,  16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 17);
    vecs[9]  = mk(OP_DIV,  16'h0005, 16'h0009, 16'h0000, 16'h0005, 4'b1000, 17);
    vecs[10] = mk(OP_SHL,  16'h8001, 16'h0000, 16'h0002, 16'h0000, 4'b0100, 1);
    vecs[11] = mk(OP_SHR,  16'h0003, 16'h0000, 16'h0001, 16'h0000, 4'b0100, 1);
    vecs[12] = mk(OP_ROL,  16'h8000, 16'h0000, 16'h0001, 16'h0000, 4'b0100, 1);
    vecs[13] = mk(OP_ROR,  16'h0002, 16'h0000, 16'h0001, 16'h0000, 4'b0000, 1);
    vecs[14] = mk(OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 4'b0000, 1);
    vecs[15] = mk(OP_OR,   16'h0F00, 16'h00F0, 16'h0FF0, 16'h0000, 4'b0000, 1);
    vecs[16] = mk(OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b1000, 1);
    vecs[17] = mk(OP_NOR,  16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'b0000, 1);
    vecs[18] = mk(OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b1000, 1);
    vecs[19] = mk(OP_XNOR, 16'h00FF, 16'h0F0F, 16'hF00F, 16'h0000, 4'b0000, 1);
    vecs[20] = mk(OP_GT,   16'h0005, 16'h0003, 16'h0001, 16'h0000, 4'b0000, 1);
    vecs[21] = mk(OP_GT,   16'h0003, 16'h0003, 16'h0000, 16'h0000, 4'b1000, 1);
    vecs[22] = mk(OP_EQ,   16'h1234, 16'h1234, 16'h0001, 16'h0000, 4'b0000, 1);
    vecs[23] = mk(OP_DIV,  16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0000, 17);
    vecs[24] = mk(OP_MUL,  16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 4'b0000, 17);
    for (int i = 0; i < NRND; i++) begin
      vecs[NFIX + i] = model(4'($urandom_range(15)), W'($urandom), W'($urandom_range(3) == 0 ? 0 : $urandom));
    end

    // reset
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; operand1 = '0; operand2 = '0;
    @(posedge clk);
    #1;
    check("in_ready_in_reset", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", {fsm_state, in_ready, out_valid, result, remainder,
                          flag_zero, flag_carry, flag_overflow, flag_dbz},
          {ST_IDLE, 2'b10, {(2*W){1'b0}}, 4'b0000});

    // table
    for (int i = 0; i < NFIX + NRND; i++) begin
      run_op(vecs[i], 0, 1'b0);
    end

    // rotate right with the response stalled for 5 cycles
    run_op(mk(OP_ROR, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 4'b0100, 1), 5, 1'b0);
    // multiply with out_ready already high before out_valid
    run_op(mk(OP_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000, 17), 0, 1'b1);
    // stalled divide
    run_op(mk(OP_DIV, 16'd1000, 16'd7, 16'd142, 16'd6, 4'b0000, 17), 3, 1'b0);

    // reset 5 cycles into a multiply: the operation is discarded
    @(negedge clk);
    in_valid = 1'b1; opcode = OP_MUL; operand1 = 16'h1234; operand2 = 16'h0056;
    exp_q.push_back(40'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("reset_mid_exec", {fsm_state, in_ready, out_valid, result, remainder,
                             flag_zero, flag_carry, flag_overflow, flag_dbz},
          {ST_IDLE, 2'b10, {(2*W){1'b0}}, 4'b0000});
    @(negedge clk);
    reset = 1'b0;
    spur = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid || result != '0) spur++;
    end
    check("no_spurious", spur, 0);
    run_op(mk(OP_ADD, 16'd2, 16'd3, 16'd5, 16'd0, 4'b0000, 1), 0, 1'b0);

    // report
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the combinational 16-bit ALU. Keeps the same 4-bit opcode map. Multiply and divide are multi-cycle iterative operations instead of single-cycle `*` and `/`. Adds status flags, a remainder output and divide-by-zero detection, and sits between the register file/accumulator path and the writeback mux.

## Interface
- `WIDTH`, 16: operand, result and remainder width (≥4).
- `clk` input 1: single clock, all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request carries a valid operation.
- `in_ready` output 1: block can accept a request.
- `opcode` input 4: operation code, same map as the existing ALU.
- `operand1`, `operand2` input WIDTH each: operands, unsigned unless noted.
- `out_valid` output 1: result and flags are valid.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: operation result.
- `remainder` output WIDTH: remainder for divide, 0 otherwise.
- `flag_zero`, `flag_carry`, `flag_overflow`, `flag_dbz` output 1 each: status flags.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`, operands and opcode are captured.
  - Multiply or divide with `operand2`≠0 goes to EXEC.
  - Every other opcode computes its result and goes to DONE.
- EXEC runs WIDTH iterations, counted by a `$clog2(WIDTH+1)`-bit counter.
  - Multiply: shift-add, 2·WIDTH-bit product.
  - Divide: restoring division.
  - When the count expires, goes to DONE.
- DONE
  - `out_valid`=1; `result`, `remainder` and flags are held stable.
  - On `out_ready`, returns to IDLE.
- Opcode map:
  - 0 add, 1 sub, 2 mul, 3 div.
  - 4 shl1, 5 shr1, 6 rol1, 7 ror1.
  - 8 and, 9 or, A xor, B nor, C nand, D xnor.
  - E greater-than (unsigned, result 1/0), F equal (result 1/0).
- Flags:
  - `flag_zero` = (`result`==0) for all opcodes.
  - `flag_carry`:
    - add: carry-out.
    - sub: borrow (`operand1`<`operand2`).
    - mul: upper WIDTH bits of the product ≠0.
    - shl/rol: `operand1[WIDTH-1]`.
    - shr/ror: `operand1[0]`.
    - all other opcodes: 0.
  - `flag_overflow`: two's-complement signed overflow for add/sub only, otherwise 0.
- Arithmetic and width rules:
  - add/sub wrap modulo 2^WIDTH.
  - mul `result` = low WIDTH bits of the product.
  - div `result` = quotient, `remainder` = operand1 mod operand2.
- Divide by zero: no EXEC. DONE is reached next cycle with `result`=all ones, `remainder`=`operand1`, `flag_dbz`=1. `flag_dbz` is 0 for every other case.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1 (combinational from state, so 1 during reset).
  - `out_valid`=0.
  - `result`, `remainder` and all flags = 0.
  - iteration counter = 0.
- Latency (cycles from the accepting edge to `out_valid` high):
  - single-cycle opcodes and divide-by-zero: 1.
  - mul and div: WIDTH+1.
- `in_ready` is 0 in EXEC and DONE. Requests are not queued; there is no back-to-back acceptance.
- Throughput: after the DONE handshake edge, the next request can be accepted one cycle later.
- `out_ready` held low: DONE persists indefinitely with all outputs stable.
- `out_ready` high before `out_valid`: has no effect until DONE.
- Reset mid-EXEC or mid-DONE: the operation is discarded, all outputs return to their reset values on the same edge, and no `out_valid` is produced.
- Operands are registered on acceptance. Input changes after the accept edge do not affect the result.

## Structure
- Shared package `seq_alu_pkg`:
  - opcode localparams (`OP_ADD`…`OP_EQ`).
  - FSM state encoding.
  - These are reused by the decoder and the testbench.
- Sub-module `seq_alu_iter`:
  - iterative mul/div datapath.
  - ports: `start`, `is_div`, operands, `done`, `product`/`quotient`, `remainder`.
  - owns the iteration counter.
- Top level: FSM, single-cycle op logic, flag logic, output registers.

## Test plan
- Test 1: WIDTH=16, add 0xFFFF+0x0001.
  - Expect 1 cycle later: `result`=0, `flag_zero`=1, `flag_carry`=1, `flag_overflow`=0.
- Test 2: sub 0x8000−0x0001.
  - Expect `result`=0x7FFF, `flag_overflow`=1, `flag_carry`=0.
- Test 3: mul 0x0100×0x0100.
  - Expect `out_valid` exactly 17 cycles after accept, `result`=0, `flag_carry`=1.
  - `in_ready`=0 throughout.
- Test 4: div 1000/7.
  - Expect `result`=142, `remainder`=6 after 17 cycles.
  - Repeat with divisor 0: expect `result`=0xFFFF, `remainder`=1000, `flag_dbz`=1 after 1 cycle.
- Test 5: ror 0x0001 with `out_ready` held low for 5 cycles.
  - Expect `result`=0x8000 and `flag_carry`=1, stable for all 5 cycles.
  - Expect IDLE the cycle after `out_ready` rises.
- Test 6: assert `reset` for one cycle 5 cycles into a mul.
  - Expect `out_valid`=0 and `result`=0 afterwards, with no spurious completion.
  - A following add 2+3 returns 5.
